// File: rtl/dm_responder_pkg.sv
// ============================================================================
// Module  : dm_responder_pkg
// Purpose : Shared FSM encodings, word-size constant and alignment helper
//           for the M-stage data-memory responder.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package dm_responder_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int DM_WORD_BYTES = 4;
  localparam int CNT_W         = 4;

  // Byte-offset bits within a word must be zero for a legal access.
  function automatic logic is_misaligned(input logic [31:0] a);
    return a[$clog2(DM_WORD_BYTES)-1:0] != '0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dm_array.sv
// ============================================================================
// Module  : dm_array
// Purpose : DEPTH x 32 storage, synchronous write, registered read,
//           asynchronous clear of every word.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dm_array #(
  parameter int DEPTH = 1024,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [31:0]      wr_data,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [31:0]      rd_data
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rd_data_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_data_q <= '0;
    end else begin
      if (wr_en) begin
        mem_q[wr_idx] <= wr_data;
      end
      if (rd_en) begin
        rd_data_q <= mem_q[rd_idx];
      end
    end
  end

  assign rd_data = rd_data_q;

endmodule

`default_nettype wire

// File: rtl/dm_responder.sv
// ============================================================================
// Module  : dm_responder
// Purpose : M-stage data-memory responder: one word load/store per request,
//           LATENCY wait states, one-cycle ack with read data or align error.
//           Optional macro DM_DISPLAY_EN prints each committed store.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dm_responder
  import dm_responder_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] pc,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        err,
  output logic        busy
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(LATENCY - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      pc_q, pc_d;
  logic             pass_q, pass_d;

  logic             w_accept;
  logic             w_commit;
  logic             w_misaligned;
  logic [IDX_W-1:0] w_idx;
  logic             w_wr_en;
  logic             w_rd_en;
  logic [31:0]      w_arr_rdata;
  logic             w_unused;

  assign w_accept     = req && (state_q == ST_IDLE || state_q == ST_DONE);
  assign w_commit     = (state_q == ST_WAIT) && (cnt_q == '0);
  assign w_misaligned = is_misaligned(addr_q);
  assign w_idx        = addr_q[IDX_W+1:2];
  assign w_wr_en      = w_commit && we_q && !w_misaligned;
  assign w_rd_en      = w_commit && !we_q && !w_misaligned;

  // pc only feeds the optional store trace; upper address bits wrap away.
  assign w_unused = ^{pc_q, addr_q[31:IDX_W+2]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      pc_q    <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      pc_q    <= pc_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req) state_d = ST_WAIT;
      ST_WAIT: if (cnt_q == '0) state_d = ST_DONE;
      ST_DONE: state_d = req ? ST_WAIT : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    pass_d  = pass_q;
    if (w_accept) begin
      we_d    = we;
      addr_d  = addr;
      wdata_d = wdata;
      pc_d    = pc;
      cnt_d   = C_CNT_LOAD;
    end else if (state_q == ST_WAIT && cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
    // Only aligned loads let array data through; stores and errors read 0.
    if (w_commit) begin
      pass_d = w_rd_en;
    end
  end

  always_comb begin
    busy  = (state_q == ST_WAIT);
    ack   = (state_q == ST_DONE);
    err   = (state_q == ST_DONE) && w_misaligned;
    rdata = pass_q ? w_arr_rdata : 32'h0;
  end

  dm_array #(
    .DEPTH (DEPTH)
  ) u_dm_array (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (w_wr_en),
    .wr_idx  (w_idx),
    .wr_data (wdata_q),
    .rd_en   (w_rd_en),
    .rd_idx  (w_idx),
    .rd_data (w_arr_rdata)
  );

`ifdef DM_DISPLAY_EN
  always_ff @(posedge clk) begin
    if (reset && w_wr_en) begin
      $display("%d@%h: *%h <= %h", $time, pc_q, addr_q, wdata_q);
    end
  end
`else
`endif

endmodule

`default_nettype wire
